mips_data_ram: RTL and testbench
================================

// Module: mips_data_ram
// PURPOSE
//  Parametrised single-port data memory for the MIPS datapath; successor of the fixed 64x32 Ram.
//  Adds byte-lane write enables, selectable combinational or registered read, and a post-reset
//  clear sequencer that zeroes every word before the memory accepts traffic.
//  Sits between the ALU result/store-data path and the writeback mux (lw/sw/sb/sh).
// PARAMETERS
//  DATA_W          32  word width in bits; must be a multiple of 8
//  ADDR_W          6   word address width; DEPTH = 2**ADDR_W words
//  SYNC_READ       0   0: spo combinational from a (Ram-compatible); 1: spo registered, 1-cycle latency
//  CLEAR_ON_RESET  1   1: run clear sequence after reset; 0: contents undefined, ready immediately
// PORTS
//  clk      in   1          rising-edge clock
//  rst_n    in   1          asynchronous active-low reset
//  a        in   ADDR_W     word address, read and write
//  d        in   DATA_W     write data
//  we       in   1          write enable, sampled at posedge clk
//  be       in   DATA_W/8   byte-lane enables; bit i qualifies d[8i+7:8i]
//  re       in   1          read request (SYNC_READ=1 only; ignored when SYNC_READ=0)
//  spo      out  DATA_W     read data
//  rd_valid out  1          SYNC_READ=1: spo valid this cycle; SYNC_READ=0: equals ~busy
//  busy     out  1          clear sequence in progress; all requests ignored
// BEHAVIOUR
//  Reset (rst_n=0, async): spo=0, rd_valid=0, clear counter=0, state=CLEAR if CLEAR_ON_RESET
//   else READY; busy=1 in CLEAR. Array contents are not touched by reset itself.
//  FSM: CLEAR -> writes 0 to mem[cnt] each cycle, cnt++; at cnt==DEPTH-1 write then -> READY
//   (busy drops the cycle after the last clear write; clear takes exactly DEPTH cycles).
//   READY is terminal until next reset. Reset mid-clear restarts at address 0.
//  While busy: we/re ignored, no array writes except clear, spo=0, rd_valid=0.
//  Write (READY, we=1): at posedge, mem[a] byte i <= d byte i for each be[i]=1; other lanes keep.
//   we=1 with be=0 is a no-op.
//  Read SYNC_READ=0: spo = mem[a] combinationally; a write to a shows new data after the edge.
//  Read SYNC_READ=1: re=1 at edge N -> spo = mem[a] and rd_valid=1 after edge N; re=0 ->
//   rd_valid=0, spo holds last value. Back-to-back re gives one word per cycle.
//  Read-during-write same address (SYNC_READ=1): write-first; spo = merged new word
//   (enabled lanes from d, others from old contents). Different address: old contents of a read.
//  Address range is exactly DEPTH, so no out-of-range case; a wraps only by width.
//  X on we/re while READY is a bench error, not handled in RTL.
// TESTING
//  1 Reset/clear: DEPTH=64, release rst_n -> busy=1 for exactly 64 clocks, then all 64 reads = 0.
//  2 Full-word write/read (SYNC_READ=0): a=1,d=23,we=1,be=4'hF one cycle -> spo=23 at a=1;
//    a=1,d=0,we=0 -> spo stays 23 (same stimulus as legacy Ram bench).
//  3 Byte lanes: mem[5]=32'h11223344, write d=32'hAABBCCDD be=4'b0101 -> mem[5]=32'h11BB33DD.
//  4 SYNC_READ=1: re=1 a=7 (mem=32'hCAFE) -> next cycle spo=32'hCAFE, rd_valid=1; re=0 -> rd_valid=0.
//  5 RDW SYNC_READ=1: mem[3]=0, we=1 re=1 a=3 d=32'h55 be=4'h1 -> next cycle spo=32'h55.
//  6 Reset mid-clear at cnt=20: assert rst_n=0 -> busy stays 1, clear restarts, ends 64 clocks
//    after release; we=1 during busy leaves mem unchanged (reads 0).

Source files
------------

// File: rtl/mips_data_ram.sv
// mips_data_ram: parametrised single-port data memory for the MIPS datapath.
// Byte-lane writes, combinational (SYNC_READ=0) or registered (SYNC_READ=1)
// read, and an optional post-reset sequencer that zeroes every word.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   a              word address (read and write)
//   d, we, be      write data, write enable, byte-lane enables
//   re             read request (registered-read mode only)
//   spo            read data
//   rd_valid       read data valid (~busy in combinational-read mode)
//   busy           clear sequence in progress, requests ignored
module mips_data_ram #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 6,
  parameter int unsigned SYNC_READ      = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     a,
  input  logic [DATA_W-1:0]     d,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic                  re,
  output logic [DATA_W-1:0]     spo,
  output logic                  rd_valid,
  output logic                  busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned LANES = DATA_W / 8;
  localparam bit          SYNC  = (SYNC_READ != 0);
  localparam bit          CLEAR = (CLEAR_ON_RESET != 0);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                clr_we_c;
  logic                busy_c;
  logic                wr_en_c;
  logic [DATA_W-1:0]   rd_word_c;
  logic [DATA_W-1:0]   merged_c;
  logic [DATA_W-1:0]   spo_q, spo_d;
  logic                rd_valid_q, rd_valid_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Clear sequencer state register; array contents are not reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR ? S_CLEAR : S_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear sequencer: one zero write per cycle, last address hands over to READY.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we_c = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_we_c = 1'b1;
        cnt_d    = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        state_d = S_READY;
      end
      default: begin
        state_d = S_READY;
      end
    endcase
  end

  assign busy_c    = (state_q == S_CLEAR);
  assign wr_en_c   = we & ~busy_c;
  assign rd_word_c = mem[a];

  // Old word with the enabled lanes replaced by d; also the write-first read value.
  always_comb begin
    merged_c = rd_word_c;
    for (int i = 0; i < int'(LANES); i++) begin
      if (be[i]) begin
        merged_c[8*i +: 8] = d[8*i +: 8];
      end
    end
  end

  // Storage array: clear writes take priority and only occur while busy.
  always_ff @(posedge clk) begin
    if (clr_we_c) begin
      mem[cnt_q] <= '0;
    end else if (wr_en_c) begin
      mem[a] <= merged_c;
    end
  end

  // Registered read path next-state (write-first on the shared address).
  always_comb begin
    spo_d      = spo_q;
    rd_valid_d = 1'b0;
    if (busy_c) begin
      spo_d = '0;
    end else if (re) begin
      spo_d      = we ? merged_c : rd_word_c;
      rd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spo_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      spo_q      <= spo_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Output select by read mode; combinational mode forces zero while clearing.
  assign spo      = SYNC ? spo_q : (busy_c ? '0 : rd_word_c);
  assign rd_valid = SYNC ? rd_valid_q : ~busy_c;
  assign busy     = busy_c;

endmodule

// File: tb/tb_mips_data_ram.sv
// tb_mips_data_ram: drives a combinational-read and a registered-read instance
// with identical stimulus and checks both against a word-array reference model.
module tb_mips_data_ram;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned NB    = DW / 8;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] a;
  logic [DW-1:0] d;
  logic          we;
  logic [NB-1:0] be;
  logic          re;

  logic [DW-1:0] spo_a, spo_s;
  logic          rd_valid_a, rd_valid_s;
  logic          busy_a, busy_s;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] m_mem [DEPTH];
  int            m_busy_left;
  logic [DW-1:0] exp_spo;
  logic          exp_rv;

  mips_data_ram #(.DATA_W(DW), .ADDR_W(AW), .SYNC_READ(0), .CLEAR_ON_RESET(1)) u_async (
    .clk(clk), .rst_n(rst_n), .a(a), .d(d), .we(we), .be(be), .re(re),
    .spo(spo_a), .rd_valid(rd_valid_a), .busy(busy_a)
  );

  mips_data_ram #(.DATA_W(DW), .ADDR_W(AW), .SYNC_READ(1), .CLEAR_ON_RESET(1)) u_sync (
    .clk(clk), .rst_n(rst_n), .a(a), .d(d), .we(we), .be(be), .re(re),
    .spo(spo_s), .rd_valid(rd_valid_s), .busy(busy_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: the model applies the inputs that were stable across the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_busy_left = DEPTH;
      exp_spo     = '0;
      exp_rv      = 1'b0;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
      exp_rv = 1'b0;
      if (m_busy_left == 0) begin
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
      end
    end else begin
      if (we) begin
        for (int i = 0; i < int'(NB); i++)
          if (be[i]) m_mem[a][8*i +: 8] = d[8*i +: 8];
      end
      if (re) begin
        exp_spo = m_mem[a];
        exp_rv  = 1'b1;
      end else begin
        exp_rv = 1'b0;
      end
    end
    #1;
  endtask

  task automatic enter_reset();
    rst_n       = 1'b0;
    m_busy_left = DEPTH;
    exp_spo     = '0;
    exp_rv      = 1'b0;
    #1;
  endtask

  // Full cross-check of both instances against the model at the current address.
  task automatic check_all(input string tag);
    logic busy_exp;
    busy_exp = (m_busy_left > 0);
    check({tag, ".busy_a"}, DW'(busy_a), DW'(busy_exp));
    check({tag, ".busy_s"}, DW'(busy_s), DW'(busy_exp));
    check({tag, ".rv_a"}, DW'(rd_valid_a), DW'(!busy_exp));
    check({tag, ".spo_a"}, spo_a, busy_exp ? '0 : m_mem[a]);
    check({tag, ".spo_s"}, spo_s, exp_spo);
    check({tag, ".rv_s"}, DW'(rd_valid_s), DW'(exp_rv));
  endtask

  // Count clocks until busy drops, attempting ignored writes/reads meanwhile.
  task automatic run_clear(input string tag);
    int n;
    n = 0;
    while (busy_a === 1'b1 && n < 200) begin
      a  = AW'($urandom_range(0, DEPTH - 1));
      d  = $urandom | 32'h1;
      we = 1'b1;
      be = '1;
      re = 1'b1;
      tick();
      n++;
      if (busy_a === 1'b1) begin
        check({tag, ".busy_spo_s"}, spo_s, '0);
        check({tag, ".busy_rv_s"}, DW'(rd_valid_s), '0);
      end
    end
    check({tag, ".clear_cycles"}, DW'(n), DW'(DEPTH));
    we = 1'b0;
    re = 1'b0;
    be = '0;
  endtask

  task automatic sweep_zero(input string tag);
    for (int i = 0; i < int'(DEPTH); i++) begin
      a  = AW'(i);
      re = 1'b1;
      we = 1'b0;
      #1;
      check({tag, ".sweep_a"}, spo_a, '0);
      tick();
      check({tag, ".sweep_s"}, spo_s, '0);
      check({tag, ".sweep_rv"}, DW'(rd_valid_s), 32'd1);
    end
    re = 1'b0;
  endtask

  task automatic write_word(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [NB-1:0] lanes);
    a  = addr;
    d  = data;
    be = lanes;
    we = 1'b1;
    re = 1'b0;
    tick();
    we = 1'b0;
  endtask

  initial begin
    a = '0; d = '0; we = 1'b0; be = '0; re = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 'x;
    m_busy_left = DEPTH;
    exp_spo = '0;
    exp_rv = 1'b0;
    rst_n = 1'b1;
    #2;
    enter_reset();

    // Reset state
    tick();
    tick();
    check_all("reset");

    // Clear sequence: exactly DEPTH busy clocks, then all words read zero
    rst_n = 1'b1;
    run_clear("clear1");
    check_all("after_clear");
    sweep_zero("clear1");

    // Full-word write/read, legacy Ram stimulus
    write_word(AW'(1), 32'd23, 4'hF);
    check("ram_wr", spo_a, 32'd23);
    a = AW'(1); d = '0; we = 1'b0;
    tick();
    check("ram_hold", spo_a, 32'd23);
    check_all("ram");

    // Byte lanes
    write_word(AW'(5), 32'h11223344, 4'hF);
    write_word(AW'(5), 32'hAABBCCDD, 4'b0101);
    check("lanes", spo_a, 32'h11BB33DD);
    check_all("lanes");

    // we with no lanes enabled leaves the word alone
    write_word(AW'(5), 32'hFFFFFFFF, 4'b0000);
    check("be0_noop", spo_a, 32'h11BB33DD);

    // Registered read latency and rd_valid
    write_word(AW'(7), 32'h0000CAFE, 4'hF);
    a = AW'(7); re = 1'b1;
    tick();
    check("sync_rd", spo_s, 32'h0000CAFE);
    check("sync_rv", DW'(rd_valid_s), 32'd1);
    re = 1'b0; a = AW'(1);
    tick();
    check("sync_rv_drop", DW'(rd_valid_s), 32'd0);
    check("sync_hold", spo_s, 32'h0000CAFE);
    check_all("sync");

    // Read-during-write, same address: write-first merged word
    a = AW'(3); d = 32'h00000055; be = 4'h1; we = 1'b1; re = 1'b1;
    tick();
    check("rdw", spo_s, 32'h00000055);
    check_all("rdw");
    we = 1'b0; re = 1'b0;

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      a  = AW'($urandom_range(0, 15));
      d  = $urandom;
      we = ($urandom_range(0, 2) != 0);
      be = NB'($urandom);
      re = ($urandom_range(0, 1) != 0);
      tick();
      check_all("rand");
    end
    we = 1'b0; re = 1'b0;

    // Reset in the middle of a clear restarts it from address 0
    enter_reset();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      a = AW'(k); d = 32'hDEAD0000 | DW'(k); we = 1'b1; be = '1;
      tick();
    end
    we = 1'b0;
    enter_reset();
    check("midclr_busy_a", DW'(busy_a), 32'd1);
    check("midclr_busy_s", DW'(busy_s), 32'd1);
    tick();
    check_all("midclr_rst");
    rst_n = 1'b1;
    run_clear("clear2");
    check_all("after_clear2");
    sweep_zero("clear2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
